// File: rtl/operand_issue.sv
// Operand issue stage: decode, RF read with writeback forwarding and a RAW scoreboard.
// Build option: define OPERAND_ISSUE_FORWARD_EN to enable the writeback forward path.
module operand_issue #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  output logic            in_ready,
  output logic [AW-1:0]   rs1_addr,
  output logic [AW-1:0]   rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_wr_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [6:0]      OPCODE,
  output logic [19:0]     INP,
  output logic [AW-1:0]   ex_rd,
  output logic [9:0]      ex_funct,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic            illegal
);

  localparam logic [6:0] OP_LI  = 7'h7F;
  localparam logic [6:0] OP_ALU = 7'h33;
  localparam logic [6:0] OP_NOP = 7'h00;

  logic [6:0]      w_op;
  logic [AW-1:0]   w_rd;
  logic            w_is_li;
  logic            w_is_alu;
  logic            w_is_ill;
  logic            w_fwd_a;
  logic            w_fwd_b;
  logic            w_haz_a;
  logic            w_haz_b;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_stall;
  logic            w_hold;
  logic            w_issue;
  logic [NREG-1:0] w_sb_nxt;

  logic [NREG-1:0] r_sb;
  logic            r_valid;
  logic [6:0]      r_op;
  logic [19:0]     r_inp;
  logic [AW-1:0]   r_rd;
  logic [9:0]      r_funct;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic            r_ill;

  assign w_op     = in_instr[6:0];
  assign w_rd     = in_instr[11:7];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign w_is_li  = (w_op == OP_LI);
  assign w_is_alu = (w_op == OP_ALU);
  assign w_is_ill = !w_is_li && !w_is_alu && (w_op != OP_NOP);
  assign w_fwd_a  = wb_wr_en && (wb_addr == rs1_addr);
  assign w_fwd_b  = wb_wr_en && (wb_addr == rs2_addr);

  always_comb begin
    w_a     = '0;
    w_b     = '0;
    w_haz_a = 1'b0;
    w_haz_b = 1'b0;
`ifdef OPERAND_ISSUE_FORWARD_EN
    if (rs1_addr != '0) begin
      w_haz_a = !w_fwd_a && r_sb[rs1_addr];
      w_a     = w_fwd_a ? wb_data : rs1_data;
    end
    if (rs2_addr != '0) begin
      w_haz_b = !w_fwd_b && r_sb[rs2_addr];
      w_b     = w_fwd_b ? wb_data : rs2_data;
    end
`else
    // Without forwarding a landing writeback is still a hazard this cycle.
    if (rs1_addr != '0) begin
      w_haz_a = w_fwd_a || r_sb[rs1_addr];
      w_a     = rs1_data;
    end
    if (rs2_addr != '0) begin
      w_haz_b = w_fwd_b || r_sb[rs2_addr];
      w_b     = rs2_data;
    end
`endif
  end

  assign w_stall  = in_valid && w_is_alu && (w_haz_a || w_haz_b);
  assign w_hold   = r_valid && !ex_ready;
  assign in_ready = !w_stall && !w_hold;
  assign w_issue  = in_valid && in_ready;

  // Set is applied after clear so a younger writer wins.
  always_comb begin
    w_sb_nxt = r_sb;
    if (wb_wr_en)
      w_sb_nxt[wb_addr] = 1'b0;
    if (w_issue && (w_is_li || w_is_alu) && (w_rd != '0))
      w_sb_nxt[w_rd] = 1'b1;
    w_sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb    <= '0;
      r_valid <= 1'b0;
      r_op    <= '0;
      r_inp   <= '0;
      r_rd    <= '0;
      r_funct <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_ill   <= 1'b0;
    end else begin
      r_sb <= w_sb_nxt;
      if (w_issue && w_is_ill)
        r_ill <= 1'b1;
      if (w_issue) begin
        r_valid <= 1'b1;
        r_op    <= w_is_ill ? OP_NOP : w_op;
        r_inp   <= in_instr[31:12];
        r_rd    <= w_rd;
        r_funct <= {in_instr[31:25], in_instr[14:12]};
        r_a     <= w_is_alu ? w_a : '0;
        r_b     <= w_is_alu ? w_b : '0;
      end else if (!w_hold) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign ex_valid  = r_valid;
  assign OPCODE    = r_op;
  assign INP       = r_inp;
  assign ex_rd     = r_rd;
  assign ex_funct  = r_funct;
  assign operand_a = r_a;
  assign operand_b = r_b;
  assign illegal   = r_ill;

endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: directed scenarios then random traffic,
// all checked against a pending-register reference model.
module tb_operand_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_wr_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_ready;
  logic        ex_valid;
  logic [6:0]  OPCODE;
  logic [19:0] INP;
  logic [4:0]  ex_rd;
  logic [9:0]  ex_funct;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        illegal;

  always #5 clk = ~clk;

  operand_issue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_wr_en(wb_wr_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid),
    .OPCODE(OPCODE), .INP(INP), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .operand_a(operand_a), .operand_b(operand_b), .illegal(illegal)
  );

  // Register file the stage reads from; written when a writeback lands.
  logic [31:0] rf [32];
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit          pend [32];
  logic        m_valid;
  logic [6:0]  m_op;
  logic [19:0] m_inp;
  logic [4:0]  m_rd;
  logic [9:0]  m_funct;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_ill;
  logic        exp_ready;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Can a source be read this cycle, and with which value?
  task automatic resolve(input logic [4:0] a, output bit ok,
                         output logic [31:0] v);
    ok = 1;
    v  = 32'h0;
    if (a == 0) return;
    if (wb_wr_en && wb_addr == a) begin
`ifdef OPERAND_ISSUE_FORWARD_EN
      v = wb_data;
`else
      ok = 0;
`endif
      return;
    end
    if (pend[a]) begin
      ok = 0;
      return;
    end
    v = rf[a];
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] ins,
                      input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic er);
    bit ok1, ok2, is_alu, is_li, is_ill, stall, hold, issue;
    logic [31:0] v1, v2;
    rst = r; in_valid = v; in_instr = ins;
    wb_wr_en = we; wb_addr = wa; wb_data = wd; ex_ready = er;
    #2;
    is_alu = ins[6:0] == 7'h33;
    is_li  = ins[6:0] == 7'h7F;
    is_ill = !is_alu && !is_li && ins[6:0] != 7'h00;
    resolve(ins[19:15], ok1, v1);
    resolve(ins[24:20], ok2, v2);
    stall = v && is_alu && !(ok1 && ok2);
    hold  = m_valid && !er;
    exp_ready = !stall && !hold;
    issue = v && exp_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("rs1_addr", 32'(rs1_addr), 32'(ins[19:15]));
    chk("rs2_addr", 32'(rs2_addr), 32'(ins[24:20]));
    if (r) begin
      foreach (pend[i]) pend[i] = 0;
      m_valid = 0; m_op = 0; m_inp = 0; m_rd = 0;
      m_funct = 0; m_a = 0; m_b = 0; m_ill = 0;
    end else begin
      if (we) pend[wa] = 0;
      if (issue && (is_li || is_alu) && ins[11:7] != 0)
        pend[ins[11:7]] = 1;
      if (issue) begin
        m_valid = 1;
        m_op    = is_ill ? 7'h00 : ins[6:0];
        m_inp   = ins[31:12];
        m_rd    = ins[11:7];
        m_funct = {ins[31:25], ins[14:12]};
        m_a     = is_alu ? v1 : 32'h0;
        m_b     = is_alu ? v2 : 32'h0;
        if (is_ill) m_ill = 1;
      end else if (!hold) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    if (!r && we && wa != 0) rf[wa] = wd;
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("OPCODE", 32'(OPCODE), 32'(m_op));
    chk("INP", 32'(INP), 32'(m_inp));
    chk("ex_rd", 32'(ex_rd), 32'(m_rd));
    chk("ex_funct", 32'(ex_funct), 32'(m_funct));
    chk("operand_a", operand_a, m_a);
    chk("operand_b", operand_b, m_b);
    chk("illegal", 32'(illegal), 32'(m_ill));
  endtask

  function automatic logic [31:0] alu(input logic [4:0] rd,
                                      input logic [4:0] s1,
                                      input logic [4:0] s2);
    return {7'h05, s2, s1, 3'h2, rd, 7'h33};
  endfunction

  function automatic logic [31:0] li(input logic [4:0] rd,
                                     input logic [19:0] imm);
    return {imm, rd, 7'h7F};
  endfunction

  logic [31:0] ins;
  logic        v;

  initial begin
    foreach (rf[i]) rf[i] = 32'h1000 + 32'(i) * 32'h11;
    rf[0] = 0;
    foreach (pend[i]) pend[i] = 0;
    m_valid = 1'bx;
    m_op = 'x; m_inp = 'x; m_rd = 'x; m_funct = 'x;
    m_a = 'x; m_b = 'x; m_ill = 1'bx;
    rst = 1; in_valid = 0; in_instr = 0;
    wb_wr_en = 0; wb_addr = 0; wb_data = 0; ex_ready = 1;
    @(posedge clk); #1;
    m_valid = 0; m_op = 0; m_inp = 0; m_rd = 0;
    m_funct = 0; m_a = 0; m_b = 0; m_ill = 0;

    // Reset held with in_valid high
    step(1, 1, li(5'd9, 20'h12345), 0, 0, 0, 1);
    step(1, 1, li(5'd9, 20'h12345), 0, 0, 0, 1);
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_illegal", 32'(illegal), 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("rst_in_ready", 32'(in_ready), 1);

    // Load-immediate, then its writeback
    step(0, 1, li(5'd3, 20'hABCDE), 0, 0, 0, 1);
    chk("li_op", 32'(OPCODE), 32'h7F);
    chk("li_inp", 32'(INP), 32'hABCDE);
    chk("li_rd", 32'(ex_rd), 3);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 5'd3, 32'hABCDE000, 1);

    // Forwarded dependency
    step(0, 1, li(5'd3, 20'h00012), 0, 0, 0, 1);
    step(0, 1, alu(5'd4, 5'd3, 5'd0), 0, 0, 0, 1);
    chk("dep_stall1", 32'(exp_ready), 0);
    step(0, 1, alu(5'd4, 5'd3, 5'd0), 1, 5'd3, 32'h12, 1);
`ifndef OPERAND_ISSUE_FORWARD_EN
    chk("dep_stall2", 32'(exp_ready), 0);
    step(0, 1, alu(5'd4, 5'd3, 5'd0), 0, 0, 0, 1);
`endif
    chk("dep_a", operand_a, 32'h12);
    chk("dep_b", operand_b, 0);
    step(0, 0, 0, 1, 5'd4, 32'h77, 1);

    // Backpressure
    step(0, 1, li(5'd6, 20'h0BEEF), 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      step(0, 1, li(5'd7, 20'h0CAFE), 0, 0, 0, 0);
    chk("bp_inp", 32'(INP), 32'h0BEEF);
    step(0, 1, li(5'd7, 20'h0CAFE), 0, 0, 0, 1);
    chk("bp_rel", 32'(INP), 32'h0CAFE);
    step(0, 0, 0, 1, 5'd6, 32'h66, 1);
    step(0, 0, 0, 1, 5'd7, 32'h88, 1);

    // Illegal opcode and the zero register
    step(0, 1, {25'h0, 7'h13}, 0, 0, 0, 1);
    chk("ill_set", 32'(illegal), 1);
    step(0, 1, alu(5'd0, 5'd0, 5'd0), 0, 0, 0, 1);
    step(0, 1, alu(5'd8, 5'd0, 5'd0), 0, 0, 0, 1);
    chk("ill_hold", 32'(illegal), 1);
    chk("x0_a", operand_a, 0);
    step(0, 0, 0, 1, 5'd8, 32'h0, 1);

    // Same-cycle set and clear of x5
    step(0, 1, li(5'd5, 20'h00001), 0, 0, 0, 1);
    step(0, 1, li(5'd5, 20'h00002), 1, 5'd5, 32'h1, 1);
    step(0, 1, alu(5'd9, 5'd5, 5'd0), 0, 0, 0, 1);
    chk("sc_stall", 32'(exp_ready), 0);
    step(0, 1, alu(5'd9, 5'd5, 5'd0), 1, 5'd5, 32'h2, 1);
`ifndef OPERAND_ISSUE_FORWARD_EN
    step(0, 1, alu(5'd9, 5'd5, 5'd0), 0, 0, 0, 1);
`endif
    chk("sc_a", operand_a, 32'h2);

    // Random traffic from a clean reset
    step(1, 0, 0, 0, 0, 0, 1);
    exp_ready = 1;
    v = 0;
    ins = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(v && !exp_ready)) begin
        int k;
        v = $urandom_range(0, 3) != 0;
        k = $urandom_range(0, 19);
        if (k < 8)
          ins = alu(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)));
        else if (k < 14)
          ins = li(5'($urandom_range(0, 7)), 20'($urandom));
        else if (k < 19)
          ins = {$urandom} & 32'hFFFF_FF80;
        else
          ins = ({$urandom} & 32'hFFFF_FF80) | 32'h13;
      end
      step(0, v, ins, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           $urandom, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
